bg_parallax_starfield: RTL



---
 rtl/bg_parallax_starfield.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bg_parallax_starfield.sv
// Procedural multi-layer parallax starfield: per-cell hashed stars, per-layer
// horizontal scroll, frame-driven twinkle, 2-clock registered RGB output.
module bg_parallax_starfield #(
    parameter int          H_RES      = 1024,
    parameter int          NUM_LAYERS = 3,
    parameter int          CELL_LOG2  = 4,
    parameter int          DENSITY    = 24,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bg_en,
    input  logic        video_active,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    input  logic        vsync,
    output logic [1:0]  R,
    output logic [1:0]  G,
    output logic [1:0]  B,
    output logic [9:0]  frame_cnt
);

    localparam int CW = 11 - CELL_LOG2;

    // Single-subtract wrap; both operands are below H_RES in legal use.
    function automatic logic [10:0] wrap_add(input logic [10:0] a, input logic [10:0] b);
        logic [11:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 12'(H_RES))
            s = s - 12'(H_RES);
        return s[10:0];
    endfunction

    function automatic logic [15:0] star_hash(input logic [15:0] cx, input logic [15:0] cy,
                                              input logic [15:0] kk);
        logic [15:0] pcx, pcy, pk, h;
        pcx = cx * 16'd40503;
        pcy = cy * 16'd9973;
        pk  = kk * 16'd4099;
        h   = pcx ^ pcy ^ pk ^ SEED;
        return h ^ (h >> 7);
    endfunction

    logic                                vsync_d;
    logic                                tick;
    logic [NUM_LAYERS-1:0][10:0]         off;
    logic [NUM_LAYERS-1:0][10:0]         off_nxt;
    logic [NUM_LAYERS-1:0][10:0]         sx;

    logic [NUM_LAYERS-1:0][CW-1:0]        s1_cx;
    logic [NUM_LAYERS-1:0][CELL_LOG2-1:0] s1_lx;
    logic [CW-1:0]                        s1_cy;
    logic [CELL_LOG2-1:0]                 s1_ly;
    logic                                 s1_va;
    logic                                 s1_en;

    logic [NUM_LAYERS-1:0][15:0]          h2;
    logic [NUM_LAYERS-1:0]                hit;
    logic [1:0]                           lvl;
    logic                                 any_hit;

    assign tick = vsync & ~vsync_d;

    always_comb begin
        off_nxt = '0;
        sx      = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            off_nxt[k] = wrap_add(off[k], 11'(1 << k));
            sx[k]      = wrap_add(pix_x, off[k]);
        end
    end

    // vsync_d resets high so a vsync held through reset does not count as a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d   <= 1'b1;
            frame_cnt <= '0;
            off       <= '0;
        end else begin
            vsync_d <= vsync;
            if (tick && bg_en) begin
                frame_cnt <= frame_cnt + 10'd1;
                off       <= off_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_cx <= '0;
            s1_lx <= '0;
            s1_cy <= '0;
            s1_ly <= '0;
            s1_va <= 1'b0;
            s1_en <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                s1_cx[k] <= sx[k][10:CELL_LOG2];
                s1_lx[k] <= sx[k][CELL_LOG2-1:0];
            end
            s1_cy <= pix_y[10:CELL_LOG2];
            s1_ly <= pix_y[CELL_LOG2-1:0];
            s1_va <= video_active;
            s1_en <= bg_en;
        end
    end

    always_comb begin
        h2  = '0;
        hit = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            h2[k]  = star_hash(16'(s1_cx[k]), 16'(s1_cy), 16'(k));
            hit[k] = (h2[k][15:8] < 8'(DENSITY))
                   && (s1_lx[k] == h2[k][CELL_LOG2-1:0])
                   && (s1_ly == h2[k][CELL_LOG2+3:4])
                   && (3'(h2[k][2:0] + frame_cnt[5:3]) != 3'd0);
        end
    end

    // Ascending scan so the nearest (highest-index) hitting layer wins.
    always_comb begin
        lvl     = 2'd0;
        any_hit = 1'b0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (hit[k]) begin
                any_hit = 1'b1;
                lvl     = (k >= 2) ? 2'd3 : 2'(k + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            R <= 2'd0;
            G <= 2'd0;
            B <= 2'd0;
        end else if (s1_va && s1_en && any_hit) begin
            R <= lvl;
            G <= lvl;
            B <= 2'd3;
        end else begin
            R <= 2'd0;
            G <= 2'd0;
            B <= 2'd0;
        end
    end

endmodule
